// File: rtl/egm_pkg.sv
// Shared types, defaults and helpers for the EGM stimulus sequencer.
package egm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StDone
    } egm_state_t;

    localparam int unsigned DefPrescale = 50;
    localparam int unsigned DefTw       = 16;

    // Increment v, clamping at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/egm_resp_sync.sv
// Two-flop synchronizer plus registered rising-edge detect; rise_o lags the pin by 3 clk.
module egm_resp_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q, rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/egm_stimulus_sequencer.sv
// Stimulus pulse-train generator with response latency and miss counting.
// Optional EGM_LATENCY_MAX_EN adds a per-run running-maximum latency output.
module egm_stimulus_sequencer
    import egm_pkg::*;
#(
    parameter int unsigned PRESCALE = DefPrescale,
    parameter int unsigned TW       = DefTw
) (
    input  logic          clk_50_clk,
    input  logic          reset_reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [TW-1:0] period,
    input  logic [TW-1:0] pulse_width,
    input  logic [TW-1:0] num_pulses,
    output logic          egm_interface_stimulus,
    input  logic          egm_interface_response,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [TW-1:0] latency,
    output logic          latency_valid,
    output logic [TW-1:0] missed_count,
    output logic [TW-1:0] pulse_count
`ifdef EGM_LATENCY_MAX_EN
    ,
    output logic [TW-1:0] latency_max
`endif
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    egm_state_t    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] period_q, width_q, num_q;
    logic [TW-1:0] phase_q, phase_d, phase_inc;
    logic [TW-1:0] lat_cnt_q, lat_cnt_d;
    logic [TW-1:0] latency_q, latency_d;
    logic [TW-1:0] missed_q, missed_d;
    logic [TW-1:0] pcount_q, pcount_d;
    logic [2:0]    tick_pipe_q, tick_pipe_d;
    logic          armed_q, armed_d;
    logic          stim_q, cfg_err_q, cfg_err_d, lat_valid_q;
    logic          tick, run, resp_rise, capture;
    logic          accept, reject, enter_high, period_end;
`ifdef EGM_LATENCY_MAX_EN
    logic [TW-1:0] lat_max_q, lat_max_d;
`endif

    egm_resp_sync u_resp_sync (
        .clk_i  (clk_50_clk),
        .rst_ni (reset_reset_n),
        .async_i(egm_interface_response),
        .rise_o (resp_rise)
    );

    assign tick      = (pre_q == PW'(PRESCALE - 1));
    assign run       = (state_q == StHigh) || (state_q == StLow);
    assign phase_inc = TW'(sat_inc(32'(phase_q), TW));
    assign capture   = run && armed_q && resp_rise;

    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= StIdle;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        reject     = 1'b0;
        enter_high = 1'b0;
        period_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (pulse_width == '0 || pulse_width >= period) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        enter_high = 1'b1;
                        state_d    = StHigh;
                    end
                end
            end
            StHigh: begin
                if (stop)                               state_d = StDone;
                else if (tick && phase_inc == width_q)  state_d = StLow;
            end
            StLow: begin
                if (stop) begin
                    state_d = StDone;
                end else if (tick && phase_inc == period_q) begin
                    period_end = 1'b1;
                    if (num_q != '0 && pcount_q == num_q) begin
                        state_d = StDone;
                    end else begin
                        enter_high = 1'b1;
                        state_d    = StHigh;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy                   = run;
        done                   = (state_q == StDone);
        egm_interface_stimulus = stim_q;
        cfg_err                = cfg_err_q;
        latency                = latency_q;
        latency_valid          = lat_valid_q;
        missed_count           = missed_q;
        pulse_count            = pcount_q;
    end

    // Ticks feeding the latency counter are delayed to match the response synchronizer,
    // so latency is measured against the pin, not the detected edge.
    always_comb begin
        pre_d       = (accept || tick) ? '0 : pre_q + PW'(1);
        tick_pipe_d = enter_high ? '0 : {tick_pipe_q[1:0], tick};
        phase_d     = enter_high ? '0 : ((run && tick) ? phase_inc : phase_q);
        armed_d     = enter_high ? 1'b1
                    : ((capture || state_d == StDone) ? 1'b0 : armed_q);
        lat_cnt_d   = enter_high ? '0
                    : ((armed_q && tick_pipe_q[2]) ? TW'(sat_inc(32'(lat_cnt_q), TW)) : lat_cnt_q);
        latency_d   = accept ? '0 : (capture ? lat_cnt_q : latency_q);
        missed_d    = accept ? '0
                    : ((period_end && armed_q && !capture) ? TW'(sat_inc(32'(missed_q), TW))
                                                           : missed_q);
        pcount_d    = accept ? TW'(1)
                    : (enter_high ? TW'(sat_inc(32'(pcount_q), TW)) : pcount_q);
        cfg_err_d   = reject ? 1'b1 : (accept ? 1'b0 : cfg_err_q);
`ifdef EGM_LATENCY_MAX_EN
        lat_max_d   = accept ? '0
                    : ((capture && lat_cnt_q > lat_max_q) ? lat_cnt_q : lat_max_q);
`endif
    end

    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_q       <= '0;
            period_q    <= '0;
            width_q     <= '0;
            num_q       <= '0;
            phase_q     <= '0;
            lat_cnt_q   <= '0;
            latency_q   <= '0;
            missed_q    <= '0;
            pcount_q    <= '0;
            tick_pipe_q <= '0;
            armed_q     <= 1'b0;
            stim_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            lat_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                period_q <= period;
                width_q  <= pulse_width;
                num_q    <= num_pulses;
            end
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            lat_cnt_q   <= lat_cnt_d;
            latency_q   <= latency_d;
            missed_q    <= missed_d;
            pcount_q    <= pcount_d;
            tick_pipe_q <= tick_pipe_d;
            armed_q     <= armed_d;
            stim_q      <= (state_d == StHigh);
            cfg_err_q   <= cfg_err_d;
            lat_valid_q <= capture;
        end
    end

`ifdef EGM_LATENCY_MAX_EN
    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) lat_max_q <= '0;
        else                lat_max_q <= lat_max_d;
    end

    assign latency_max = lat_max_q;
`endif

endmodule

// File: tb/tb_egm_stimulus_sequencer.sv
// Scoreboard bench for egm_stimulus_sequencer (PRESCALE=2); expected latencies are queued
// by the stimulus side and popped by a monitor on every latency_valid.
module tb_egm_stimulus_sequencer;

    localparam int unsigned P  = 2;
    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          resp = 1'b0;
    logic [TW-1:0] period = '0;
    logic [TW-1:0] width = '0;
    logic [TW-1:0] num = '0;
    logic          stimulus, busy, done, cfg_err, latency_valid;
    logic [TW-1:0] latency, missed_count, pulse_count;
`ifdef EGM_LATENCY_MAX_EN
    logic [TW-1:0] latency_max;
`endif

    egm_stimulus_sequencer #(
        .PRESCALE(P),
        .TW      (TW)
    ) dut (
        .clk_50_clk            (clk),
        .reset_reset_n         (rst_n),
        .start                 (start),
        .stop                  (stop),
        .period                (period),
        .pulse_width           (width),
        .num_pulses            (num),
        .egm_interface_stimulus(stimulus),
        .egm_interface_response(resp),
        .busy                  (busy),
        .done                  (done),
        .cfg_err               (cfg_err),
        .latency               (latency),
        .latency_valid         (latency_valid),
        .missed_count          (missed_count),
        .pulse_count           (pulse_count)
`ifdef EGM_LATENCY_MAX_EN
        ,
        .latency_max           (latency_max)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_lat_q[$];
    int resp_cyc_q[$];
    int resp_dly_q[$];
    bit resp_double = 1'b0;
    int done_cnt = 0, lv_cnt = 0, rise_cnt = 0;
    int done_cyc = 0, start_cyc = 0;
    int last_rise_cyc = -1, exp_per_clk = 0, exp_hi_clk = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response driver: on each stimulus rise, pop a delay in ticks (0 = no response).
    initial begin : resp_drv
        bit stim_prev;
        int d;
        stim_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (stimulus && !stim_prev && resp_dly_q.size() > 0) begin
                stim_prev = 1'b1;
                d = resp_dly_q.pop_front();
                if (d > 0) begin
                    repeat (d * P) @(posedge clk);
                    #1 resp = 1'b1;
                    resp_cyc_q.push_back(cyc);
                    repeat (P) @(posedge clk);
                    #1 resp = 1'b0;
                    if (resp_double) begin
                        repeat (3 * P) @(posedge clk);
                        #1 resp = 1'b1;
                        repeat (P) @(posedge clk);
                        #1 resp = 1'b0;
                    end
                end
            end else begin
                stim_prev = stimulus;
            end
        end
    end

    initial begin : out_mon
        int e;
        forever begin
            @(negedge clk);
            if (latency_valid) begin
                lv_cnt++;
                if (exp_lat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_latency_valid: got latency %0d expected none", latency);
                end else begin
                    e = exp_lat_q.pop_front();
                    chk("latency", latency, e);
                    if (resp_cyc_q.size() > 0) chk("lv_delay", cyc - resp_cyc_q.pop_front(), 4);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", busy, 0);
            end
        end
    end

    initial begin : stim_mon
        bit prev_s;
        int hi_len;
        prev_s = 1'b0;
        hi_len = 0;
        forever begin
            @(negedge clk);
            if (stimulus) begin
                if (!prev_s) begin
                    rise_cnt++;
                    if (last_rise_cyc >= 0) chk("period_clk", cyc - last_rise_cyc, exp_per_clk);
                    last_rise_cyc = cyc;
                    hi_len = 0;
                end
                hi_len++;
            end else if (prev_s && exp_hi_clk > 0) begin
                chk("width_clk", hi_len, exp_hi_clk);
            end
            prev_s = stimulus;
        end
    end

    task automatic do_start(input int per, input int w, input int n, input bit chk_w);
        @(posedge clk);
        #1;
        period = TW'(per);
        width = TW'(w);
        num = TW'(n);
        exp_per_clk = per * int'(P);
        exp_hi_clk = chk_w ? w * int'(P) : 0;
        last_rise_cyc = -1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        while (rise_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("rise_seen", rise_cnt, target);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, l0, r0;
        repeat (3) @(negedge clk);
        chk("rst_stim", stimulus, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_lv", latency_valid, 0);
        chk("rst_latency", latency, 0);
        chk("rst_missed", missed_count, 0);
        chk("rst_pcount", pulse_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // No response: every pulse is missed.
        d0 = done_cnt; l0 = lv_cnt; r0 = rise_cnt;
        do_start(10, 3, 4, 1'b1);
        wait_done(d0, 200);
        @(negedge clk);
        chk("t1_done_time", done_cyc - start_cyc, 1 + 4 * 10 * P);
        chk("t1_rises", rise_cnt - r0, 4);
        chk("t1_missed", missed_count, 4);
        chk("t1_pcount", pulse_count, 4);
        chk("t1_lv", lv_cnt - l0, 0);
        chk("t1_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("t1_one_done", done_cnt - d0, 1);

        // Response 5 ticks after each rise.
        d0 = done_cnt; l0 = lv_cnt;
        for (int i = 0; i < 4; i++) begin
            resp_dly_q.push_back(5);
            exp_lat_q.push_back(5);
        end
        do_start(10, 3, 4, 1'b1);
        wait_done(d0, 200);
        @(negedge clk);
        chk("t2_lv", lv_cnt - l0, 4);
        chk("t2_missed", missed_count, 0);
        chk("t2_latency_hold", latency, 5);
        chk("t2_sb_empty", exp_lat_q.size(), 0);

        // Two response edges per period at ticks 2 and 6: only the first counts.
        d0 = done_cnt; l0 = lv_cnt;
        resp_double = 1'b1;
        for (int i = 0; i < 2; i++) begin
            resp_dly_q.push_back(2);
            exp_lat_q.push_back(2);
        end
        do_start(10, 3, 2, 1'b1);
        wait_done(d0, 120);
        @(negedge clk);
        resp_double = 1'b0;
        chk("t3_lv", lv_cnt - l0, 2);
        chk("t3_missed", missed_count, 0);
        chk("t3_sb_empty", exp_lat_q.size(), 0);

        // Rejected configurations, then an accepted start clears cfg_err.
        d0 = done_cnt; r0 = rise_cnt;
        do_start(10, 10, 1, 1'b1);
        @(negedge clk);
        chk("t4_cfg_err", cfg_err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_stim", stimulus, 0);
        do_start(10, 0, 1, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_cfg_err_w0", cfg_err, 1);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_rise", rise_cnt - r0, 0);
        do_start(10, 3, 1, 1'b1);
        @(negedge clk);
        chk("t4_cfg_err_clr", cfg_err, 0);
        chk("t4_busy_run", busy, 1);
        chk("t4_stim_run", stimulus, 1);
        wait_done(d0, 80);
        @(negedge clk);
        chk("t4_missed", missed_count, 1);
        chk("t4_pcount", pulse_count, 1);

        // Continuous run aborted in the 3rd pulse's high phase.
        d0 = done_cnt; r0 = rise_cnt;
        do_start(10, 3, 0, 1'b0);
        wait_rises(r0 + 3, 200);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        chk("t5_stim_low", stimulus, 0);
        chk("t5_done", done, 1);
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_pcount", pulse_count, 3);
        chk("t5_missed", missed_count, 2);
        chk("t5_one_done", done_cnt - d0, 1);

        // Asynchronous reset in the middle of a high phase.
        d0 = done_cnt;
        do_start(10, 3, 0, 1'b0);
        @(negedge clk);
        chk("t6_stim_before", stimulus, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_stim", stimulus, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pcount", pulse_count, 0);
        chk("t6_missed", missed_count, 0);
        chk("t6_latency", latency, 0);
        chk("t6_cfg_err", cfg_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_idle", busy, 0);

`ifdef EGM_LATENCY_MAX_EN
        d0 = done_cnt;
        resp_dly_q.push_back(3);
        resp_dly_q.push_back(7);
        resp_dly_q.push_back(4);
        exp_lat_q.push_back(3);
        exp_lat_q.push_back(7);
        exp_lat_q.push_back(4);
        do_start(10, 3, 3, 1'b1);
        wait_done(d0, 120);
        @(negedge clk);
        chk("t7_latency_max", latency_max, 7);
        chk("t7_latency", latency, 4);
        chk("t7_sb_empty", exp_lat_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/egm_stimulus_sequencer.md
# egm_stimulus_sequencer

Hardware sequencer for the EGM test interface. It generates a programmable train of stimulus pulses on `egm_interface_stimulus` and timestamps the first rising edge of `egm_interface_response` after each pulse. It reports per-pulse latency and a count of missed responses. It sits between the EGM conduit pins and a PIO or register bank driven by the Nios II, and replaces the software polling loop.

## Interface
Parameters:
- `PRESCALE`, default 50: clk cycles per timing tick (1 us at 50 MHz).
- `TW`, default 16: width of all tick, latency and pulse counters.

Ports:
- `clk_50_clk`  in  1  system clock.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored while `busy`.
- `stop`  in  1  one-cycle pulse that aborts a run.
- `period`  in  TW  ticks from one stimulus rise to the next; sampled at `start`.
- `pulse_width`  in  TW  stimulus high time in ticks; sampled at `start`.
- `num_pulses`  in  TW  pulses per run; 0 means continuous until `stop`.
- `egm_interface_stimulus`  out  1  stimulus to the EGM.
- `egm_interface_response`  in  1  asynchronous response from the EGM.
- `busy`  out  1  high while a run is active.
- `done`  out  1  one-cycle pulse when a run completes or is aborted.
- `cfg_err`  out  1  sticky; set by a rejected `start`, cleared by the next accepted `start`.
- `latency`  out  TW  ticks from stimulus rise to response rise, for the last answered pulse.
- `latency_valid`  out  1  one-cycle pulse when `latency` updates.
- `missed_count`  out  TW  pulses with no response in the current run.
- `pulse_count`  out  TW  pulses issued in the current run.

## Operation
- Response path:
  - Two-flop synchronizer, then a rising-edge detect.
  - Detected edge (`resp_rise`) lags the pin by 3 clk.
- Tick generator:
  - Free-running modulo-`PRESCALE` counter; emits a one-clk `tick`.
  - Restarts at the cycle `start` is accepted, so the first tick lands `PRESCALE` clk after start.
- State machine:
  - IDLE: stimulus low. On `start`:
    - if `pulse_width`==0 or `pulse_width`>=`period`: set `cfg_err`, stay IDLE, no `done`;
    - otherwise latch config, clear counters and `cfg_err`, go HIGH.
  - HIGH: stimulus high. Phase counter counts ticks. At `pulse_width` ticks, go LOW.
  - LOW: stimulus low. At `period` ticks from the rise:
    - if `pulse_count`==`num_pulses` (nonzero), go DONE;
    - else start the next pulse (phase counter to 0, go HIGH).
  - DONE: pulse `done` for one cycle, return to IDLE.
- Entering HIGH increments `pulse_count`, arms the response window and clears the latency counter.
- Latency counter increments on each tick while armed.
- On `resp_rise` while armed:
  - `latency` takes the counter value (saturating at 2^TW-1);
  - `latency_valid` pulses;
  - window disarms. Later edges in the same period are ignored.
- If the window is still armed at the end of the period, `missed_count` increments. This is also checked at the final pulse, before DONE.
- `resp_rise` while disarmed or in IDLE is ignored.
- All counters saturate at 2^TW-1; none wrap.
- `stop` in HIGH or LOW:
  - stimulus drops next cycle;
  - the in-flight pulse is not counted as missed;
  - go DONE.
- `stop` in IDLE is ignored.
- `start` and `stop` in the same IDLE cycle: `start` wins; `stop` is ignored.

## Timing
- Reset values:
  - stimulus, `busy`, `done`, `latency_valid`, `cfg_err` = 0;
  - `latency`, `missed_count`, `pulse_count` = 0;
  - state IDLE, prescaler 0.
- Reset mid-run drops stimulus asynchronously; no `done`.
- Stimulus rises 1 clk after an accepted `start`. `busy` rises in the same cycle.
- Stimulus edges are registered and align 1 clk after the qualifying tick.
- `latency_valid` fires 4 clk after the response pin rise: 3 for sync and edge detect, 1 to register.
- `done` fires 1 clk after the last period boundary; `busy` falls with it.
- `pulse_count`, `missed_count` and `latency` hold after DONE until the next accepted `start`.

## Configuration
- `EGM_LATENCY_MAX_EN` defined:
  - adds output `latency_max` (TW): running maximum of `latency` within a run;
  - cleared at accepted `start`, reset to 0;
  - updates in the same cycle as `latency`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `egm_pkg`:
  - state enum `egm_state_t` (IDLE, HIGH, LOW, DONE);
  - default `PRESCALE`/`TW` constants;
  - `sat_inc` function for saturating increment.
- One sub-module, `egm_resp_sync`: 2-flop synchronizer plus rising-edge detector, with async active-low reset to 0.

## Test plan
- PRESCALE=2, period=10, width=3, num_pulses=4, response tied low:
  - 4 stimulus pulses, each 3 ticks high on a 10-tick period;
  - `missed_count`=4, `pulse_count`=4, one `done`, no `latency_valid`.
- Same config, response rises 5 ticks after each stimulus rise:
  - `latency`=5 with `latency_valid` ×4, `missed_count`=0;
  - each `latency_valid` 4 clk after its response edge.
- Response pulses twice per period (ticks 2 and 6): exactly one `latency_valid` per period, `latency`=2.
- start with width=10, period=10 → `cfg_err`=1, `busy`=0, no stimulus, no `done`. A following valid start clears `cfg_err`.
- num_pulses=0, `stop` in the 3rd pulse's HIGH phase:
  - stimulus low next cycle, `done` pulses;
  - `pulse_count`=3, in-flight pulse not counted as missed.
- Reset asserted mid-HIGH: stimulus low immediately, all outputs 0. With `EGM_LATENCY_MAX_EN`, latencies 3,7,4 give `latency_max`=7.
